// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the ALU block.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOR = 3'b100,
    OP_XOR = 3'b101
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational operation core: maps captured operands and opcode to a WIDTH-bit value.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_NOR:  o_y = ~(i_a | i_b);
      OP_XOR:  o_y = i_a ^ i_b;
      // 110 and 111 are reserved and yield zero
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// Two-state start/done ALU: capture operands on start, compute and register result next cycle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Start_signal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_y;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_y  (w_y)
  );

  // Start is only honoured in IDLE, so a held start relaunches every second cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start_signal) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result <= w_y;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases then random operations against a reference model.
module tb_alu;

  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             Start_signal;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             done;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  alu #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .Start_signal (Start_signal),
    .a            (a),
    .b            (b),
    .op           (op),
    .done         (done),
    .result       (result)
  );

  always #5 clock = ~clock;

  // Reference model using plain integer arithmetic modulo 2^16.
  function automatic logic [WIDTH-1:0] model(input int unsigned ma, input int unsigned mb,
                                             input int unsigned mop);
    int unsigned m;
    int unsigned r;
    m = 32'h1_0000;
    case (mop)
      0: r = (ma + mb) % m;
      1: r = (ma + m - mb) % m;
      2: r = ma & mb;
      3: r = ma | mb;
      4: r = (m - 1) - (ma | mb);
      5: r = ma ^ mb;
      default: r = 0;
    endcase
    return r[WIDTH-1:0];
  endfunction

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle start; optionally scramble inputs and re-pulse start during EXEC.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic [2:0] top, input bit scramble, input bit restart);
    logic [WIDTH-1:0] exp;
    exp = model(ta, tb_, top);
    a = ta; b = tb_; op = top; Start_signal = 1'b1;
    tick();
    check({tag, "_exec_done"}, {15'd0, done}, 16'd0);
    Start_signal = restart;
    if (scramble) begin
      a = ~ta; b = ta ^ tb_; op = top + 3'd3;
    end
    tick();
    Start_signal = 1'b0;
    check({tag, "_done"}, {15'd0, done}, 16'd1);
    check({tag, "_result"}, result, exp);
    tick();
    check({tag, "_done_low"}, {15'd0, done}, 16'd0);
    check({tag, "_hold"}, result, exp);
    if (restart) begin
      tick();
      check({tag, "_no_second_done"}, {15'd0, done}, 16'd0);
    end
    $display("op %s a=%h b=%h op=%0d result=%h expected=%h", tag, ta, tb_, top, result, exp);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [2:0]       rop;

    reset = 1'b1; Start_signal = 1'b1; a = 16'hFA50; b = 16'hA55A; op = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_done", {15'd0, done}, 16'd0);
      check("reset_result", result, 16'd0);
    end
    Start_signal = 1'b0;
    reset = 1'b0;
    tick();
    check("post_reset_done", {15'd0, done}, 16'd0);
    $display("reset released result=%h done=%b", result, done);

    for (int k = 0; k < 8; k++) begin
      rop = k[2:0];
      run_op($sformatf("dir_op%0d", k), 16'hFA50, 16'hA55A, rop, 1'b0, 1'b0);
    end
    check("const_add", model(16'hFA50, 16'hA55A, 0), 16'h9FAA);
    run_op("sub_wrap", 16'h0000, 16'h0001, 3'b001, 1'b0, 1'b0);
    check("sub_wrap_val", result, 16'hFFFF);
    run_op("scramble", 16'h1234, 16'h0F0F, 3'b101, 1'b1, 1'b0);
    run_op("restart_in_exec", 16'h8000, 16'h8001, 3'b000, 1'b0, 1'b1);

    // Held start: completions every second cycle.
    a = 16'h0102; b = 16'h0304; op = 3'b000; Start_signal = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("held_done_%0d", k), {15'd0, done}, (k % 2 == 1) ? 16'd1 : 16'd0);
    end
    Start_signal = 1'b0;
    check("held_result", result, 16'h0406);
    tick();
    $display("held start result=%h", result);

    // Reset during EXEC aborts the operation.
    a = 16'h00FF; b = 16'h0001; op = 3'b000; Start_signal = 1'b1;
    tick();
    Start_signal = 1'b0; reset = 1'b1;
    tick();
    check("abort_done", {15'd0, done}, 16'd0);
    check("abort_result", result, 16'd0);
    reset = 1'b0;
    tick();
    check("abort_idle_done", {15'd0, done}, 16'd0);
    $display("reset during exec result=%h done=%b", result, done);
    run_op("after_abort", 16'h00FF, 16'h0001, 3'b000, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rop = 3'($urandom_range(0, 7));
      run_op($sformatf("rand%0d", n), ra, rb, rop, n[0], n[1] & n[2]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
